// File: rtl/signal_pkg.sv
// Shared lamp codes, controller state encoding and timer helper for the
// adaptive phase controller.
package signal_pkg;

    localparam logic [1:0] LAMP_GREEN  = 2'b01;
    localparam logic [1:0] LAMP_YELLOW = 2'b10;
    localparam logic [1:0] LAMP_RED    = 2'b11;

    typedef enum logic [1:0] {
        ST_ALL_RED = 2'd0,
        ST_GREEN   = 2'd1,
        ST_YELLOW  = 2'd2
    } phase_state_e;

    // Increment that sticks at max_value instead of wrapping.
    function automatic int unsigned sat_inc(input int unsigned value,
                                            input int unsigned max_value);
        return (value >= max_value) ? max_value : value + 1;
    endfunction

endpackage

// File: rtl/rr_phase_arbiter.sv
// Combinational round-robin pick: first set request strictly after the
// pointer, searching upward with wrap. The pointer register lives in the parent.
module rr_phase_arbiter
    import signal_pkg::*;
#(
    parameter int unsigned NUM_PHASES = 4,
    parameter int unsigned PH_W       = $clog2(NUM_PHASES)
) (
    input  logic [NUM_PHASES-1:0] i_req,
    input  logic [PH_W-1:0]       i_ptr,
    output logic [PH_W-1:0]       o_grant_c,
    output logic                  o_valid_c
);

    logic [PH_W-1:0] w_idx;

    // Walk from the farthest candidate down to ptr+1 so the nearest hit wins.
    always_comb begin
        o_grant_c = '0;
        o_valid_c = 1'b0;
        w_idx     = '0;
        for (int k = NUM_PHASES; k >= 1; k--) begin
            w_idx = PH_W'((32'(i_ptr) + 32'(k)) % NUM_PHASES);
            if (i_req[w_idx]) begin
                o_grant_c = w_idx;
                o_valid_c = 1'b1;
            end
        end
    end

endmodule

// File: rtl/adaptive_phase_controller.sv
// Demand-driven N-phase signal controller: GREEN -> YELLOW -> ALL_RED with
// programmable timers, min/max green extension and emergency pre-emption.
module adaptive_phase_controller
    import signal_pkg::*;
#(
    parameter int unsigned NUM_PHASES = 4,
    parameter int unsigned CNT_W      = 8,
    parameter int unsigned PH_W       = $clog2(NUM_PHASES)
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic [NUM_PHASES-1:0]   demand,
    input  logic [CNT_W-1:0]        green_min,
    input  logic [CNT_W-1:0]        green_max,
    input  logic [CNT_W-1:0]        yellow_time,
    input  logic [CNT_W-1:0]        allred_time,
    input  logic                    preempt_req,
    input  logic [PH_W-1:0]         preempt_phase,
    output logic [2*NUM_PHASES-1:0] lights,
    output logic [PH_W-1:0]         active_phase,
    output logic [NUM_PHASES-1:0]   calls,
    output logic                    preempt_active
);

    localparam int unsigned PH_SPAN = 1 << PH_W;
    localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;
    localparam logic [PH_SPAN-1:0] PH_VALID = {PH_SPAN{1'b1}} >> (PH_SPAN - NUM_PHASES);

    phase_state_e              r_state, w_state_nx;
    logic [PH_W-1:0]           r_phase, w_phase_nx;
    logic [PH_W-1:0]           r_ptr, w_ptr_nx;
    logic [CNT_W-1:0]          r_timer, w_timer_nx;
    logic [NUM_PHASES-1:0]     r_calls, w_calls_nx;
    logic [2*NUM_PHASES-1:0]   r_lights, w_lights_nx;
    logic                      r_preempt_active, w_preempt_active_nx;

    logic [CNT_W-1:0]          w_gmin, w_gmax, w_ytime, w_artime;
    logic                      w_pre;
    logic                      w_competing;
    logic [PH_W-1:0]           w_arb_grant;
    logic                      w_arb_valid;

    // A programmed duration of zero behaves as a single cycle.
    function automatic logic [CNT_W-1:0] at_least_one(input logic [CNT_W-1:0] t);
        return (t == '0) ? CNT_W'(1) : t;
    endfunction

    assign w_gmin      = at_least_one(green_min);
    assign w_gmax      = at_least_one(green_max);
    assign w_ytime     = at_least_one(yellow_time);
    assign w_artime    = at_least_one(allred_time);
    assign w_pre       = preempt_req & PH_VALID[preempt_phase];
    assign w_competing = |(r_calls & ~(NUM_PHASES'(1) << r_phase));

    rr_phase_arbiter #(
        .NUM_PHASES (NUM_PHASES),
        .PH_W       (PH_W)
    ) u_arb (
        .i_req      (r_calls),
        .i_ptr      (r_ptr),
        .o_grant_c  (w_arb_grant),
        .o_valid_c  (w_arb_valid)
    );

    // Next state, timer, call latch, lamps and pre-emption flag.
    always_comb begin
        w_state_nx          = r_state;
        w_phase_nx          = r_phase;
        w_ptr_nx            = r_ptr;
        w_timer_nx          = CNT_W'(sat_inc(32'(r_timer), CNT_MAX));
        w_calls_nx          = r_calls | demand;
        w_lights_nx         = {NUM_PHASES{LAMP_RED}};
        w_preempt_active_nx = 1'b0;

        case (r_state)
            ST_ALL_RED: begin
                if (r_timer >= w_artime) begin
                    if (w_pre) begin
                        w_state_nx = ST_GREEN;
                        w_phase_nx = preempt_phase;
                    end else if (w_arb_valid) begin
                        w_state_nx = ST_GREEN;
                        w_phase_nx = w_arb_grant;
                        w_ptr_nx   = w_arb_grant;
                    end
                end
            end
            ST_GREEN: begin
                if ((w_pre && (preempt_phase != r_phase)) ||
                    (!w_pre && (r_timer >= w_gmin) && w_competing &&
                     (!demand[r_phase] || (r_timer >= w_gmax)))) begin
                    w_state_nx = ST_YELLOW;
                end
            end
            ST_YELLOW: begin
                if (r_timer >= w_ytime) begin
                    w_state_nx = ST_ALL_RED;
                end
            end
            default: w_state_nx = ST_ALL_RED;
        endcase

        if (w_state_nx != r_state) begin
            w_timer_nx = CNT_W'(1);
        end

        // Demand on the phase already green is not latched; entering green clears it.
        if (r_state == ST_GREEN) begin
            w_calls_nx[r_phase] = r_calls[r_phase];
        end
        if ((w_state_nx == ST_GREEN) && (r_state != ST_GREEN)) begin
            w_calls_nx[w_phase_nx] = 1'b0;
        end

        if (w_state_nx == ST_GREEN) begin
            w_lights_nx[{w_phase_nx, 1'b0} +: 2] = LAMP_GREEN;
        end else if (w_state_nx == ST_YELLOW) begin
            w_lights_nx[{w_phase_nx, 1'b0} +: 2] = LAMP_YELLOW;
        end

        w_preempt_active_nx = w_pre &&
            !((w_state_nx == ST_GREEN) && (w_phase_nx != preempt_phase));
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state          <= ST_ALL_RED;
            r_phase          <= '0;
            r_ptr            <= PH_W'(NUM_PHASES - 1);
            r_timer          <= '0;
            r_calls          <= '0;
            r_lights         <= {NUM_PHASES{LAMP_RED}};
            r_preempt_active <= 1'b0;
        end else begin
            r_state          <= w_state_nx;
            r_phase          <= w_phase_nx;
            r_ptr            <= w_ptr_nx;
            r_timer          <= w_timer_nx;
            r_calls          <= w_calls_nx;
            r_lights         <= w_lights_nx;
            r_preempt_active <= w_preempt_active_nx;
        end
    end

    assign lights         = r_lights;
    assign active_phase   = r_phase;
    assign calls          = r_calls;
    assign preempt_active = r_preempt_active;

endmodule

// File: tb/tb_adaptive_phase_controller.sv
// Directed and table-driven bench for adaptive_phase_controller with a
// lamp-safety monitor running alongside every phase of the test.
module tb_adaptive_phase_controller;

    localparam int unsigned NP = 4;
    localparam int unsigned CW = 8;
    localparam int unsigned PW = 2;

    logic          clock = 1'b0;
    logic          reset_n;
    logic [NP-1:0] demand;
    logic [CW-1:0] green_min, green_max, yellow_time, allred_time;
    logic          preempt_req;
    logic [PW-1:0] preempt_phase;
    logic [2*NP-1:0] lights;
    logic [PW-1:0] active_phase;
    logic [NP-1:0] calls;
    logic          preempt_active;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [NP-1:0]   dem;
        logic [2*NP-1:0] lights;
        logic [NP-1:0]   calls;
        logic [PW-1:0]   phase;
    } rr_vec_t;

    rr_vec_t tbl [18];

    always #5 clock = ~clock;

    adaptive_phase_controller #(
        .NUM_PHASES (NP),
        .CNT_W      (CW),
        .PH_W       (PW)
    ) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .demand         (demand),
        .green_min      (green_min),
        .green_max      (green_max),
        .yellow_time    (yellow_time),
        .allred_time    (allred_time),
        .preempt_req    (preempt_req),
        .preempt_phase  (preempt_phase),
        .lights         (lights),
        .active_phase   (active_phase),
        .calls          (calls),
        .preempt_active (preempt_active)
    );

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got 0x%0h, want 0x%0h", name, $time, act, exp);
        end
    endtask

    task automatic do_reset();
        demand        = '0;
        preempt_req   = 1'b0;
        preempt_phase = '0;
        reset_n       = 1'b0;
        #2;
        chk("async_reset_lights", 32'(lights), 32'hFF);
        chk("async_reset_calls", 32'(calls), 32'h0);
        repeat (3) @(posedge clock);
        #1;
        reset_n = 1'b1;
    endtask

    // Measure how many cycles phase 0 stays green with a competitor on phase 1.
    task automatic green_len(input bit hold, input int exp_len);
        int  cnt;
        bit  done;
        do_reset();
        demand = 4'b0001;
        step();
        demand = hold ? 4'b0001 : 4'b0000;
        step();
        chk("mm_green_entry", 32'(lights), 32'hFD);
        cnt    = 1;
        done   = 1'b0;
        demand = hold ? 4'b0011 : 4'b0010;
        for (int i = 0; i < 40 && !done; i++) begin
            step();
            demand = hold ? 4'b0001 : 4'b0000;
            if (lights == 8'hFD) cnt++;
            else done = 1'b1;
        end
        chk(hold ? "mm_len_max" : "mm_len_min", 32'(cnt), 32'(exp_len));
        chk("mm_exit_yellow", 32'(lights), 32'hFE);
        step();
        chk("mm_yellow2", 32'(lights), 32'hFE);
        step();
        chk("mm_allred", 32'(lights), 32'hFF);
        step();
        chk("mm_next_green1", 32'(lights), 32'hF7);
        demand = '0;
    endtask

    // Safety monitor: one non-red lamp at most, green only out of all-red,
    // yellow only after green, and no green dropping straight to red.
    logic [2*NP-1:0] mon_prev;
    bit              mon_prev_ok = 1'b0;
    int              mon_nonred;
    bit              mon_bad;
    logic [1:0]      mon_l, mon_pl;

    always @(negedge clock) begin
        if (!reset_n) begin
            mon_prev_ok <= 1'b0;
        end else begin
            mon_nonred = 0;
            mon_bad    = 1'b0;
            for (int i = 0; i < NP; i++) begin
                mon_l  = lights[2*i +: 2];
                mon_pl = mon_prev[2*i +: 2];
                if (mon_l != 2'b11) mon_nonred++;
                if (mon_prev_ok) begin
                    if (mon_l == 2'b01 && mon_pl != 2'b01 && mon_prev != 8'hFF) mon_bad = 1'b1;
                    if (mon_l == 2'b10 && mon_pl != 2'b01 && mon_pl != 2'b10) mon_bad = 1'b1;
                    if (mon_pl == 2'b01 && mon_l == 2'b11) mon_bad = 1'b1;
                end
            end
            n_vec++;
            if (mon_nonred > 1 || mon_bad) begin
                n_err++;
                $display("FAIL safety @%0t: got lights 0x%0h after 0x%0h, want one legal lamp step",
                         $time, lights, mon_prev);
            end
            mon_prev    <= lights;
            mon_prev_ok <= 1'b1;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no completion, want finish before timeout");
        $fatal(1, "watchdog expired");
    end

    initial begin
        tbl[0]  = '{4'b1011, 8'hFF, 4'hB, 2'd0};
        tbl[1]  = '{4'b0000, 8'hFD, 4'hA, 2'd0};
        tbl[2]  = '{4'b0000, 8'hFD, 4'hA, 2'd0};
        tbl[3]  = '{4'b0000, 8'hFE, 4'hA, 2'd0};
        tbl[4]  = '{4'b0000, 8'hFE, 4'hA, 2'd0};
        tbl[5]  = '{4'b0000, 8'hFF, 4'hA, 2'd0};
        tbl[6]  = '{4'b0001, 8'hF7, 4'h9, 2'd1};
        tbl[7]  = '{4'b0000, 8'hF7, 4'h9, 2'd1};
        tbl[8]  = '{4'b0000, 8'hFB, 4'h9, 2'd1};
        tbl[9]  = '{4'b0000, 8'hFB, 4'h9, 2'd1};
        tbl[10] = '{4'b0000, 8'hFF, 4'h9, 2'd1};
        tbl[11] = '{4'b0000, 8'h7F, 4'h1, 2'd3};
        tbl[12] = '{4'b0000, 8'h7F, 4'h1, 2'd3};
        tbl[13] = '{4'b0000, 8'hBF, 4'h1, 2'd3};
        tbl[14] = '{4'b0000, 8'hBF, 4'h1, 2'd3};
        tbl[15] = '{4'b0000, 8'hFF, 4'h1, 2'd3};
        tbl[16] = '{4'b0000, 8'hFD, 4'h0, 2'd0};
        tbl[17] = '{4'b0000, 8'hFD, 4'h0, 2'd0};

        reset_n       = 1'b0;
        demand        = '0;
        preempt_req   = 1'b0;
        preempt_phase = '0;
        green_min     = 8'd2;
        green_max     = 8'd3;
        yellow_time   = 8'd2;
        allred_time   = 8'd3;

        // Reset and idle.
        repeat (3) begin
            step();
            chk("reset_lights", 32'(lights), 32'hFF);
            chk("reset_calls", 32'(calls), 32'h0);
            chk("reset_phase", 32'(active_phase), 32'h0);
            chk("reset_preempt", 32'(preempt_active), 32'h0);
        end
        reset_n = 1'b1;
        for (int i = 0; i < 50; i++) begin
            step();
            chk("idle_lights", 32'(lights), 32'hFF);
            chk("idle_calls", 32'(calls), 32'h0);
        end

        // Single call on phase 2 from rest.
        demand = 4'b0100;
        step();
        chk("single_latch_lights", 32'(lights), 32'hFF);
        chk("single_latch_calls", 32'(calls), 32'h4);
        demand = 4'b0000;
        step();
        chk("single_green_lights", 32'(lights), 32'hDF);
        chk("single_green_calls", 32'(calls), 32'h0);
        chk("single_green_phase", 32'(active_phase), 32'h2);
        for (int i = 0; i < 20; i++) begin
            step();
            chk("single_hold", 32'(lights), 32'hDF);
        end

        // Round-robin service order 0, 1, 3, 0 after a mid-green reset.
        allred_time = 8'd1;
        do_reset();
        for (int i = 0; i < 18; i++) begin
            demand = tbl[i].dem;
            step();
            chk($sformatf("rr%0d_lights", i), 32'(lights), 32'(tbl[i].lights));
            chk($sformatf("rr%0d_calls", i), 32'(calls), 32'(tbl[i].calls));
            chk($sformatf("rr%0d_phase", i), 32'(active_phase), 32'(tbl[i].phase));
            chk($sformatf("rr%0d_preempt", i), 32'(preempt_active), 32'h0);
        end

        // Min/max green extension.
        green_min   = 8'd5;
        green_max   = 8'd12;
        yellow_time = 8'd2;
        allred_time = 8'd1;
        green_len(1'b1, 12);
        green_len(1'b0, 5);

        // Pre-emption of phase 1 below green_min, steering to phase 3.
        green_min   = 8'd10;
        green_max   = 8'd20;
        yellow_time = 8'd1;
        allred_time = 8'd2;
        do_reset();
        demand = 4'b0010;
        step();
        chk("pre_calls", 32'(calls), 32'h2);
        demand = 4'b0000;
        step();
        step();
        chk("pre_green1", 32'(lights), 32'hF7);
        chk("pre_green1_flag", 32'(preempt_active), 32'h0);
        step();
        chk("pre_green1_e2", 32'(lights), 32'hF7);
        preempt_req   = 1'b1;
        preempt_phase = 2'd3;
        step();
        chk("pre_yellow1", 32'(lights), 32'hFB);
        chk("pre_yellow1_flag", 32'(preempt_active), 32'h1);
        step();
        chk("pre_allred_a", 32'(lights), 32'hFF);
        chk("pre_allred_a_flag", 32'(preempt_active), 32'h1);
        step();
        chk("pre_allred_b", 32'(lights), 32'hFF);
        step();
        chk("pre_green3", 32'(lights), 32'h7F);
        chk("pre_green3_phase", 32'(active_phase), 32'h3);
        chk("pre_green3_flag", 32'(preempt_active), 32'h1);
        demand = 4'b0101;
        for (int i = 0; i < 12; i++) begin
            step();
            demand = 4'b0000;
            chk("pre_hold", 32'(lights), 32'h7F);
            chk("pre_hold_flag", 32'(preempt_active), 32'h1);
        end
        chk("pre_hold_calls", 32'(calls), 32'h5);
        preempt_req = 1'b0;
        step();
        chk("pre_release_yellow", 32'(lights), 32'hBF);
        chk("pre_release_flag", 32'(preempt_active), 32'h0);
        step();
        step();
        step();
        chk("pre_ptr_kept_lights", 32'(lights), 32'hDF);
        chk("pre_ptr_kept_phase", 32'(active_phase), 32'h2);
        chk("pre_ptr_kept_calls", 32'(calls), 32'h1);

        // Random traffic under the safety monitor.
        do_reset();
        for (int i = 0; i < 10000; i++) begin
            if (i % 200 == 0) begin
                green_min   = 8'($urandom_range(0, 4));
                green_max   = 8'($urandom_range(0, 8));
                yellow_time = 8'($urandom_range(0, 3));
                allred_time = 8'($urandom_range(0, 3));
            end
            demand = 4'($urandom);
            if ($urandom_range(0, 63) == 0) preempt_req = ~preempt_req;
            if ($urandom_range(0, 31) == 0) preempt_phase = 2'($urandom);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
